// File: rtl/bcd_conv_arbiter_if.sv
// Bundle between bcd_conv_arbiter, its requesters and the shared
// binary-to-BCD converter. The arbiter connects through the slave modport,
// and the environment (clients plus converter) through the master modport.
interface bcd_conv_arbiter_if #(
    parameter int N_REQ = 4
);
    // Requester side
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0][7:0] req_data;
    logic [N_REQ-1:0]      ack;
    logic [2:0][3:0]       bcd_out;
    logic                  err;
    logic                  busy;

    // Converter side
    logic                  conv_start;
    logic [7:0]            conv_in;
    logic                  conv_ready;
    logic                  conv_done;
    logic [2:0][3:0]       conv_bcd;

    modport slave (
        input  req, req_data, conv_ready, conv_done, conv_bcd,
        output ack, bcd_out, err, busy, conv_start, conv_in
    );

    modport master (
        output req, req_data, conv_ready, conv_done, conv_bcd,
        input  ack, bcd_out, err, busy, conv_start, conv_in
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin scheduler sharing a single 8-bit binary-to-BCD converter
// among N_REQ requesters. The flow is IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
// The winner's operand is latched and the converter is started. Its digits
// are captured on done, then returned together with a one-hot ack pulse.
//
// Optional feature: define BCD_ARB_TIMEOUT_EN to abort WAIT after
// TIMEOUT_CYCLES cycles without conv_done. The abort returns bcd_out=0 with
// err pulsing alongside ack. Without the macro, err is constant 0 and only
// conv_done leaves WAIT.
module bcd_conv_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bcd_conv_arbiter_if.slave         bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // One-hot decode of a requester index
    function automatic logic [N_REQ-1:0] onehot_f(input logic [PW-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == PW'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    sel_q, sel_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             init_q, init_d;
    logic [7:0]       conv_in_q, conv_in_d;
    logic             conv_start_q, conv_start_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             err_q, err_d;
    logic [2:0][3:0]  bcd_q, bcd_d;
    logic             busy_q, busy_d;

    logic [PW-1:0]    win_s;
    logic             found_s;

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
`else
    logic             unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
`endif

    // Round-robin search starting just after the last served requester
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found_s && bus.req[idx]) begin
                win_s   = PW'(idx);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and output computation for the scheduler FSM
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        init_d       = init_q;
        conv_in_d    = conv_in_q;
        conv_start_d = 1'b0;
        ack_d        = '0;
        err_d        = 1'b0;
        bcd_d        = bcd_q;
`ifdef BCD_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // conv_ready is untrusted until the first launch (converter has no reset)
                if (found_s && (bus.conv_ready || init_q)) begin
                    sel_d        = win_s;
                    conv_in_d    = bus.req_data[win_s];
                    conv_start_d = 1'b1;
                    state_d      = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                init_d  = 1'b0;
                state_d = ST_WAIT;
`ifdef BCD_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (bus.conv_done) begin
                    bcd_d   = bus.conv_bcd;
                    ack_d   = onehot_f(sel_q);
                    state_d = ST_RESP;
                end else begin
`ifdef BCD_ARB_TIMEOUT_EN
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: the converter state is unknown, so re-arm init
                        bcd_d   = '0;
                        ack_d   = onehot_f(sel_q);
                        err_d   = 1'b1;
                        init_d  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ST_WAIT;
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_RESP: begin
                ptr_d   = sel_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            ptr_q        <= PW'(N_REQ - 1);
            init_q       <= 1'b1;
            conv_in_q    <= 8'd0;
            conv_start_q <= 1'b0;
            ack_q        <= '0;
            err_q        <= 1'b0;
            bcd_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            init_q       <= init_d;
            conv_in_q    <= conv_in_d;
            conv_start_q <= conv_start_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            bcd_q        <= bcd_d;
            busy_q       <= busy_d;
        end
    end

`ifdef BCD_ARB_TIMEOUT_EN
    // WAIT-state cycle counter for the abort path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.ack        = ack_q;
    assign bus.bcd_out    = bcd_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
    assign bus.conv_start = conv_start_q;
    assign bus.conv_in    = conv_in_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed testbench for bcd_conv_arbiter with a behavioural converter model
// (done 10 cycles after start). Timeout checks depend on BCD_ARB_TIMEOUT_EN.
module tb_bcd_conv_arbiter;

    localparam int N  = 4;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bcd_conv_arbiter_if #(.N_REQ(N)) bus ();

    bcd_conv_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural converter: restarts on every start and has no reset
    logic [7:0] m_op    = 8'd0;
    int         m_cnt   = 0;
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;
    logic       m_mute  = 1'b0;
    logic       m_xrdy  = 1'b0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (bus.conv_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
            m_op   <= bus.conv_in;
        end else if (m_busy) begin
            if (m_cnt == 9) begin
                m_busy <= 1'b0;
                m_done <= ~m_mute;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    assign bus.conv_ready = m_xrdy ? 1'bx : ~m_busy;
    assign bus.conv_done  = m_done;
    assign bus.conv_bcd   = {4'(m_op / 8'd100), 4'((m_op / 8'd10) % 8'd10), 4'(m_op % 8'd10)};

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until ack appears; returns number of cycles taken
    task automatic wait_ack(input string tag, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (bus.ack == '0 && cycles < 80);
        if (bus.ack == '0) chk({tag, "_ack_seen"}, 32'(bus.ack != '0), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic single(input int idx, input logic [7:0] op, input logic [11:0] exp, input string tag);
        int c;
        bus.req_data[idx] = op;
        bus.req[idx]      = 1'b1;
        wait_ack(tag, c);
        chk({tag, "_ack"}, 32'(bus.ack), 32'(1 << idx));
        chk({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp));
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        bus.req = '0;
        tick();
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    logic [N-1:0] exp_ack [5];
    logic [11:0]  exp_bcd [5];

    initial begin
        int c;
        logic seen;
        bus.req      = '0;
        bus.req_data = '0;

        // Reset values while rst_n is held low
        tick();
        tick();
        chk("rst_ack",   32'(bus.ack),        32'd0);
        chk("rst_bcd",   32'(bus.bcd_out),    32'd0);
        chk("rst_err",   32'(bus.err),        32'd0);
        chk("rst_busy",  32'(bus.busy),       32'd0);
        chk("rst_start", 32'(bus.conv_start), 32'd0);
        chk("rst_cin",   32'(bus.conv_in),    32'd0);
        rst_n = 1'b1;
        tick();

        // Single request 255 with cycle-accurate latency
        bus.req_data[0] = 8'd255;
        bus.req[0]      = 1'b1;
        tick();
        chk("lat_start", 32'(bus.conv_start), 32'd1);
        chk("lat_cin",   32'(bus.conv_in),    32'd255);
        chk("lat_busy",  32'(bus.busy),       32'd1);
        tick();
        chk("lat_start_pulse", 32'(bus.conv_start), 32'd0);
        wait_ack("lat", c);
        chk("lat_cycles", 32'(c + 2),    32'd12);
        chk("lat_ack",    32'(bus.ack),  32'b0001);
        chk("lat_bcd",    32'(bus.bcd_out), 32'h255);
        chk("lat_err",    32'(bus.err),  32'd0);
        bus.req = '0;
        tick();
        chk("lat_ack_pulse", 32'(bus.ack), 32'd0);
        chk("lat_hold_bcd",  32'(bus.bcd_out), 32'h255);

        // Boundary operands
        single(0, 8'd0,   12'h000, "b0");
        single(1, 8'd9,   12'h009, "b9");
        single(2, 8'd100, 12'h100, "b100");
        single(3, 8'd199, 12'h199, "b199");

        // Contention: all four held after reset
        do_reset();
        bus.req_data[0] = 8'd17;
        bus.req_data[1] = 8'd38;
        bus.req_data[2] = 8'd64;
        bus.req_data[3] = 8'd201;
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_bcd = '{12'h017, 12'h038, 12'h064, 12'h201, 12'h017};
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack("rr", c);
            chk($sformatf("rr%0d_ack", k), 32'(bus.ack), 32'(exp_ack[k]));
            chk($sformatf("rr%0d_bcd", k), 32'(bus.bcd_out), 32'(exp_bcd[k]));
        end
        bus.req = '0;
        tick();

        // Fairness: req[1] held, req[3] rises while 1 is being served
        bus.req_data[1] = 8'd55;
        bus.req_data[3] = 8'd77;
        bus.req[1] = 1'b1;
        tick();
        tick();
        tick();
        bus.req[3] = 1'b1;
        wait_ack("fair0", c);
        chk("fair0_ack", 32'(bus.ack), 32'b0010);
        chk("fair0_bcd", 32'(bus.bcd_out), 32'h055);
        wait_ack("fair1", c);
        chk("fair1_ack", 32'(bus.ack), 32'b1000);
        chk("fair1_bcd", 32'(bus.bcd_out), 32'h077);
        bus.req[3] = 1'b0;
        wait_ack("fair2", c);
        chk("fair2_ack", 32'(bus.ack), 32'b0010);
        chk("fair2_bcd", 32'(bus.bcd_out), 32'h055);
        bus.req = '0;
        tick();

        // Reset during WAIT: outputs clear at once, no ack afterwards
        bus.req_data[1] = 8'd123;
        bus.req[1] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_ack",  32'(bus.ack),     32'd0);
        chk("mid_bcd",  32'(bus.bcd_out), 32'd0);
        chk("mid_busy", 32'(bus.busy),    32'd0);
        chk("mid_cin",  32'(bus.conv_in), 32'd0);
        bus.req = '0;
        tick();
        rst_n  = 1'b1;
        m_xrdy = 1'b1;
        bus.req_data[2] = 8'd42;
        bus.req[2] = 1'b1;
        wait_ack("post", c);
        chk("post_ack", 32'(bus.ack), 32'b0100);
        chk("post_bcd", 32'(bus.bcd_out), 32'h042);
        bus.req = '0;
        m_xrdy  = 1'b0;
        tick();

        // Converter that never signals done
        m_mute = 1'b1;
        bus.req_data[0] = 8'd77;
        bus.req[0] = 1'b1;
        tick();
        tick();
`ifdef BCD_ARB_TIMEOUT_EN
        wait_ack("to", c);
        chk("to_cycles", 32'(c),          32'(TO));
        chk("to_ack",    32'(bus.ack),    32'b0001);
        chk("to_err",    32'(bus.err),    32'd1);
        chk("to_bcd",    32'(bus.bcd_out), 32'd0);
        bus.req = '0;
        tick();
        chk("to_err_pulse", 32'(bus.err), 32'd0);
`else
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.ack != '0) seen = 1'b1;
        end
        chk("noto_busy", 32'(bus.busy), 32'd1);
        chk("noto_ack",  32'(seen),     32'd0);
        chk("noto_err",  32'(bus.err),  32'd0);
        bus.req = '0;
`endif
        m_mute = 1'b0;
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
